dll_discriminator: RTL and testbench

- Parametrised early/late code discriminator for the GPS DLL.
- Integrate-and-dumps early and late I/Q correlator samples over a programmable number of valid samples.
- Computes a selectable discriminator (power or magnitude-approximation) through one multiplier shared across sequenced cycles.
- Delivers a scaled, saturated result with a valid pulse to the loop filter.

---
 rtl/dll_discriminator.sv | 231 +++++++++++++++++++++++
 tb/tb_dll_discriminator.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dll_discriminator.sv
// Early/late I/Q integrate-and-dump feeding a sequenced power or magnitude DLL discriminator.
// Define DLL_DISC_PROMPT_EN to add prompt I/Q accumulation and a prompt power output.
module dll_discriminator #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 32,
  parameter int N_INT = 10000,
  parameter int OUT_W = 32,
  parameter int SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_e_i,
  input  logic [IN_W-1:0]  in_e_q,
  input  logic [IN_W-1:0]  in_l_i,
  input  logic [IN_W-1:0]  in_l_q,
`ifdef DLL_DISC_PROMPT_EN
  input  logic [IN_W-1:0]  in_p_i,
  input  logic [IN_W-1:0]  in_p_q,
  output logic [2*ACC_W:0] prompt_pwr,
`endif
  input  logic             mode,
  output logic [OUT_W-1:0] disc_out,
  output logic             disc_valid,
  output logic             ovf,
  output logic             busy
);

`ifdef DLL_DISC_PROMPT_EN
  localparam int NCH = 6;
`else
  localparam int NCH = 4;
`endif
  localparam int CNT_W = $clog2(N_INT);
  localparam int PW    = 2*ACC_W + 1;
  localparam int RAW_W = 2*ACC_W + 2;
  localparam logic signed [RAW_W-1:0] MAXV = {{(RAW_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RAW_W-1:0] MINV = ~MAXV;

  typedef enum logic [3:0] {IDLE, SQ_EI, SQ_EQ, SQ_LI, SQ_LQ, SQ_PI, SQ_PQ, COMBINE, OUT} state_t;
  state_t state, state_nxt;

  logic [IN_W-1:0]  smp  [NCH];
  logic [ACC_W-1:0] acc  [NCH];
  logic [ACC_W-1:0] sum  [NCH];
  logic [ACC_W-1:0] hold [NCH];
  logic [ACC_W:0]   ext, s;
  logic             sat_hit, sat, hold_sat, hold_mode, dump;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    smp[0] = in_e_i;
    smp[1] = in_e_q;
    smp[2] = in_l_i;
    smp[3] = in_l_q;
`ifdef DLL_DISC_PROMPT_EN
    smp[4] = in_p_i;
    smp[5] = in_p_q;
`endif
  end

  // Add in ACC_W+1 bits; a mismatch of the top two bits means the sum left the ACC_W range.
  always_comb begin
    sat_hit = 1'b0;
    ext     = '0;
    s       = '0;
    for (int k = 0; k < NCH; k++) begin
      ext    = {{(ACC_W-IN_W+1){smp[k][IN_W-1]}}, smp[k]};
      s      = {acc[k][ACC_W-1], acc[k]} + ext;
      sum[k] = s[ACC_W-1:0];
      if (s[ACC_W] != s[ACC_W-1]) begin
        sat_hit = 1'b1;
        sum[k]  = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end
  end

  assign dump = in_valid && !clear && (cnt == CNT_W'(N_INT-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NCH; k++) begin
        acc[k]  <= '0;
        hold[k] <= '0;
      end
      cnt       <= '0;
      sat       <= 1'b0;
      hold_sat  <= 1'b0;
      hold_mode <= 1'b0;
    end else if (clear) begin
      for (int k = 0; k < NCH; k++) acc[k] <= '0;
      cnt <= '0;
      sat <= 1'b0;
    end else if (in_valid) begin
      if (dump) begin
        for (int k = 0; k < NCH; k++) begin
          hold[k] <= sum[k];
          acc[k]  <= '0;
        end
        hold_mode <= mode;
        hold_sat  <= sat | sat_hit;
        cnt       <= '0;
        sat       <= 1'b0;
      end else begin
        for (int k = 0; k < NCH; k++) acc[k] <= sum[k];
        cnt <= cnt + CNT_W'(1);
        sat <= sat | sat_hit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (dump) state_nxt = SQ_EI;
        SQ_EI:   state_nxt = SQ_EQ;
        SQ_EQ:   state_nxt = SQ_LI;
        SQ_LI:   state_nxt = SQ_LQ;
`ifdef DLL_DISC_PROMPT_EN
        SQ_LQ:   state_nxt = SQ_PI;
        SQ_PI:   state_nxt = SQ_PQ;
        SQ_PQ:   state_nxt = COMBINE;
`else
        SQ_LQ:   state_nxt = COMBINE;
`endif
        COMBINE: state_nxt = OUT;
        OUT:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  logic [ACC_W-1:0] mul_a;
  always_comb begin
    busy  = (state != IDLE);
    mul_a = '0;
    case (state)
      SQ_EI:   mul_a = hold[0];
      SQ_EQ:   mul_a = hold[1];
      SQ_LI:   mul_a = hold[2];
      SQ_LQ:   mul_a = hold[3];
`ifdef DLL_DISC_PROMPT_EN
      SQ_PI:   mul_a = hold[4];
      SQ_PQ:   mul_a = hold[5];
`endif
      default: mul_a = '0;
    endcase
  end

  logic signed [2*ACC_W-1:0] sq;
  assign sq = $signed(mul_a) * $signed(mul_a);

  // One extra bit so that |-2^(ACC_W-1)| is representable.
  function automatic logic [ACC_W:0] mag(input logic [ACC_W-1:0] v);
    logic [ACC_W:0] e;
    e   = {v[ACC_W-1], v};
    mag = v[ACC_W-1] ? (~e + (ACC_W+1)'(1)) : e;
  endfunction

  logic [PW-1:0] pe, pl;
  logic signed [RAW_W-1:0] raw, shifted;
  logic [OUT_W-1:0] sat_val, disc_sat;
  logic clip, disc_clip;

  always_comb begin
    raw     = $signed({1'b0, pe}) - $signed({1'b0, pl});
    shifted = raw >>> SHIFT;
    clip    = (shifted > MAXV) || (shifted < MINV);
    if (shifted > MAXV)      sat_val = MAXV[OUT_W-1:0];
    else if (shifted < MINV) sat_val = MINV[OUT_W-1:0];
    else                     sat_val = shifted[OUT_W-1:0];
  end

`ifdef DLL_DISC_PROMPT_EN
  logic [PW-1:0] pp;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pe         <= '0;
      pl         <= '0;
      disc_sat   <= '0;
      disc_clip  <= 1'b0;
      disc_out   <= '0;
      disc_valid <= 1'b0;
      ovf        <= 1'b0;
`ifdef DLL_DISC_PROMPT_EN
      pp         <= '0;
      prompt_pwr <= '0;
`endif
    end else begin
      disc_valid <= 1'b0;
      if (!clear) begin
        case (state)
          SQ_EI:   pe <= hold_mode ? ({{ACC_W{1'b0}}, mag(hold[0])} + {{ACC_W{1'b0}}, mag(hold[1])})
                                   : {1'b0, sq};
          SQ_EQ:   if (!hold_mode) pe <= pe + {1'b0, sq};
          SQ_LI:   pl <= hold_mode ? ({{ACC_W{1'b0}}, mag(hold[2])} + {{ACC_W{1'b0}}, mag(hold[3])})
                                   : {1'b0, sq};
          SQ_LQ:   if (!hold_mode) pl <= pl + {1'b0, sq};
`ifdef DLL_DISC_PROMPT_EN
          SQ_PI:   pp <= {1'b0, sq};
          SQ_PQ:   pp <= pp + {1'b0, sq};
`endif
          COMBINE: begin
            disc_sat  <= sat_val;
            disc_clip <= clip;
          end
          OUT: begin
            disc_out   <= disc_sat;
            ovf        <= hold_sat | disc_clip;
            disc_valid <= 1'b1;
`ifdef DLL_DISC_PROMPT_EN
            prompt_pwr <= pp;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dll_discriminator.sv
// Directed bench for dll_discriminator: a 32-bit accumulator instance and a 16-bit one share stimulus.
module tb_dll_discriminator;
`ifdef DLL_DISC_PROMPT_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 7;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic mode = 1'b0;
  logic [15:0] e_i = '0, e_q = '0, l_i = '0, l_q = '0;
  logic [31:0] disc_a, disc_b;
  logic valid_a, valid_b, ovf_a, ovf_b, busy_a, busy_b;
`ifdef DLL_DISC_PROMPT_EN
  logic [15:0] p_i = '0, p_q = '0;
  logic [64:0] ppwr_a;
  logic [32:0] ppwr_b;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dll_discriminator #(.IN_W(16), .ACC_W(32), .N_INT(8), .OUT_W(32), .SHIFT(0)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .in_e_i(e_i), .in_e_q(e_q), .in_l_i(l_i), .in_l_q(l_q),
`ifdef DLL_DISC_PROMPT_EN
    .in_p_i(p_i), .in_p_q(p_q), .prompt_pwr(ppwr_a),
`endif
    .mode(mode), .disc_out(disc_a), .disc_valid(valid_a), .ovf(ovf_a), .busy(busy_a)
  );

  dll_discriminator #(.IN_W(16), .ACC_W(16), .N_INT(8), .OUT_W(32), .SHIFT(0)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .in_e_i(e_i), .in_e_q(e_q), .in_l_i(l_i), .in_l_q(l_q),
`ifdef DLL_DISC_PROMPT_EN
    .in_p_i(p_i), .in_p_q(p_q), .prompt_pwr(ppwr_b),
`endif
    .mode(mode), .disc_out(disc_b), .disc_valid(valid_b), .ovf(ovf_b), .busy(busy_b)
  );

  task automatic send(input int ei, input int eq, input int li, input int lq);
    @(negedge clk);
    e_i = 16'(ei);
    e_q = 16'(eq);
    l_i = 16'(li);
    l_q = 16'(lq);
    in_valid = 1'b1;
  endtask

  // Eight valid samples, then wait (bounded) for disc_valid; lat=0 on timeout.
  task automatic run_period(input int ei, input int eq, input int li, input int lq, output int lat);
    for (int i = 0; i < 8; i++) send(ei, eq, li, lq);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!valid_a && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!valid_a) lat = 0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (disc_a !== 32'd0) begin fails++; $display("FAIL reset_disc got %0d want 0", disc_a); end
    tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid_a); end
    tests++; if (ovf_a !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", ovf_a); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy_a); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_power;
    int lat;
    mode = 1'b0;
    run_period(100, 0, 50, 0, lat);
    tests++; if (lat !== LAT) begin fails++; $display("FAIL power_latency got %0d want %0d", lat, LAT); end
    tests++; if ($signed(disc_a) !== 480000) begin fails++; $display("FAIL power_value got %0d want 480000", $signed(disc_a)); end
    tests++; if (ovf_a !== 1'b0) begin fails++; $display("FAIL power_ovf got %b want 0", ovf_a); end
    @(negedge clk);
    tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL power_pulse_width got %b want 0", valid_a); end
    tests++; if ($signed(disc_a) !== 480000) begin fails++; $display("FAIL power_hold got %0d want 480000", $signed(disc_a)); end
  endtask

  task automatic test_magnitude;
    int lat;
    mode = 1'b1;
    run_period(100, 0, 50, 0, lat);
    tests++; if (lat !== LAT) begin fails++; $display("FAIL mag_latency got %0d want %0d", lat, LAT); end
    tests++; if ($signed(disc_a) !== 400) begin fails++; $display("FAIL mag_value got %0d want 400", $signed(disc_a)); end
    run_period(100, -100, 50, 0, lat);
    tests++; if ($signed(disc_a) !== 1200) begin fails++; $display("FAIL mag_neg_q got %0d want 1200", $signed(disc_a)); end
    mode = 1'b0;
    run_period(100, -100, 50, 0, lat);
    tests++; if ($signed(disc_a) !== 1120000) begin fails++; $display("FAIL power_neg_q got %0d want 1120000", $signed(disc_a)); end
  endtask

  task automatic test_gaps;
    int n = 0, pos = -1, val = 0;
    mode = 1'b0;
    e_i = 16'd100; e_q = '0; l_i = 16'd50; l_q = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid_a) begin n++; pos = i; val = $signed(disc_a); end
      in_valid = (i < 16) && (i % 2 == 0);
    end
    tests++; if (n !== 1) begin fails++; $display("FAIL gaps_pulses got %0d want 1", n); end
    tests++; if (pos !== 14 + LAT) begin fails++; $display("FAIL gaps_position got %0d want %0d", pos, 14 + LAT); end
    tests++; if (val !== 480000) begin fails++; $display("FAIL gaps_value got %0d want 480000", val); end
  endtask

  task automatic test_saturation;
    int lat;
    mode = 1'b0;
    run_period(32767, 0, 0, 0, lat);
    tests++; if ($signed(disc_b) !== 1073676289) begin fails++; $display("FAIL acc_sat_value got %0d want 1073676289", $signed(disc_b)); end
    tests++; if (ovf_b !== 1'b1 || valid_b !== 1'b1) begin fails++; $display("FAIL acc_sat_ovf got ovf=%b valid=%b want 1 1", ovf_b, valid_b); end
    tests++; if (disc_a !== 32'h7fff_ffff) begin fails++; $display("FAIL out_clip_pos got %h want 7fffffff", disc_a); end
    tests++; if (ovf_a !== 1'b1) begin fails++; $display("FAIL out_clip_pos_ovf got %b want 1", ovf_a); end
    run_period(0, 0, 32767, 0, lat);
    tests++; if (disc_a !== 32'h8000_0000) begin fails++; $display("FAIL out_clip_neg got %h want 80000000", disc_a); end
    tests++; if ($signed(disc_b) !== -1073676289) begin fails++; $display("FAIL acc_sat_neg got %0d want -1073676289", $signed(disc_b)); end
    run_period(100, 0, 50, 0, lat);
    tests++; if (ovf_a !== 1'b0 || ovf_b !== 1'b0) begin fails++; $display("FAIL clean_ovf got a=%b b=%b want 0 0", ovf_a, ovf_b); end
    tests++; if ($signed(disc_b) !== 480000) begin fails++; $display("FAIL clean_value_b got %0d want 480000", $signed(disc_b)); end
  endtask

  task automatic test_mode_latch;
    int lat;
    for (int i = 0; i < 8; i++) begin
      send(100, 0, 50, 0);
      mode = (i != 7);
    end
    @(negedge clk);
    in_valid = 1'b0;
    mode = 1'b1;
    lat = 1;
    while (!valid_a && lat < 20) begin @(negedge clk); lat++; end
    tests++; if (lat !== LAT) begin fails++; $display("FAIL mode_latch_latency got %0d want %0d", lat, LAT); end
    tests++; if ($signed(disc_a) !== 480000) begin fails++; $display("FAIL mode_latch_value got %0d want 480000", $signed(disc_a)); end
    mode = 1'b0;
  endtask

  task automatic test_back_to_back;
    int n = 0;
    int r[2];
    int p[2];
    r[0] = 0; r[1] = 0; p[0] = 0; p[1] = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid_a) begin
        if (n < 2) begin r[n] = $signed(disc_a); p[n] = i; end
        n++;
      end
      in_valid = (i < 16);
      e_i = (i < 8) ? 16'd100 : 16'd10;
      l_i = (i < 8) ? 16'd50 : 16'd0;
      e_q = '0; l_q = '0;
    end
    tests++; if (n !== 2) begin fails++; $display("FAIL b2b_pulses got %0d want 2", n); end
    tests++; if (r[0] !== 480000) begin fails++; $display("FAIL b2b_first got %0d want 480000", r[0]); end
    tests++; if (r[1] !== 6400) begin fails++; $display("FAIL b2b_second got %0d want 6400", r[1]); end
    tests++; if (p[1] - p[0] !== 8) begin fails++; $display("FAIL b2b_spacing got %0d want 8", p[1] - p[0]); end
  endtask

  task automatic test_clear;
    int n = 0, lat;
    for (int i = 0; i < 8; i++) begin
      send(100, 0, 50, 0);
      clear = (i == 7);
    end
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin @(negedge clk); if (valid_a) n++; end
    tests++; if (n !== 0) begin fails++; $display("FAIL clear_dump_pulses got %0d want 0", n); end
    tests++; if ($signed(disc_a) !== 6400) begin fails++; $display("FAIL clear_dump_hold got %0d want 6400", $signed(disc_a)); end
    run_period(10, 0, 20, 0, lat);
    tests++; if ($signed(disc_a) !== -19200) begin fails++; $display("FAIL clear_next_value got %0d want -19200", $signed(disc_a)); end
    tests++; if (lat !== LAT) begin fails++; $display("FAIL clear_next_latency got %0d want %0d", lat, LAT); end
    // Abort during SQ_LI: third negedge after the dumping edge.
    for (int i = 0; i < 8; i++) send(100, 0, 50, 0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL clear_busy_before got %b want 1", busy_a); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL clear_busy_after got %b want 0", busy_a); end
    n = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (valid_a) n++; end
    tests++; if (n !== 0) begin fails++; $display("FAIL clear_compute_pulses got %0d want 0", n); end
    tests++; if ($signed(disc_a) !== -19200) begin fails++; $display("FAIL clear_compute_hold got %0d want -19200", $signed(disc_a)); end
  endtask

  task automatic test_reset_mid;
    int lat, n = 0;
    for (int i = 0; i < 4; i++) send(100, 0, 50, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    tests++; if (disc_a !== 32'd0 || ovf_a !== 1'b0 || busy_a !== 1'b0 || valid_a !== 1'b0) begin
      fails++; $display("FAIL rst_mid_outputs got disc=%0d ovf=%b busy=%b valid=%b want 0", disc_a, ovf_a, busy_a, valid_a); end
    @(negedge clk);
    rst = 1'b1;
    run_period(100, 0, 50, 0, lat);
    tests++; if (lat !== LAT) begin fails++; $display("FAIL rst_mid_latency got %0d want %0d", lat, LAT); end
    tests++; if ($signed(disc_a) !== 480000) begin fails++; $display("FAIL rst_mid_value got %0d want 480000", $signed(disc_a)); end
    for (int i = 0; i < 8; i++) send(100, 0, 50, 0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (busy_a !== 1'b0 || disc_a !== 32'd0) begin
      fails++; $display("FAIL rst_compute_outputs got busy=%b disc=%0d want 0 0", busy_a, disc_a); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (valid_a) n++; end
    tests++; if (n !== 0) begin fails++; $display("FAIL rst_compute_pulses got %0d want 0", n); end
    run_period(10, 0, 20, 0, lat);
    tests++; if ($signed(disc_a) !== -19200) begin fails++; $display("FAIL rst_compute_next got %0d want -19200", $signed(disc_a)); end
  endtask

  initial begin
    test_reset();
    test_power();
    test_magnitude();
    test_gaps();
    test_saturation();
    test_mode_latch();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
